// File: rtl/tl_pkg.sv
// Shared TL transmit-path types: stream beat, traffic class, header field
// positions and the data-credit calculation applied at SOP.
package tl_pkg;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } tl_stream_t;

    typedef enum logic [1:0] {
        TC_P   = 2'd0,
        TC_NP  = 2'd1,
        TC_CPL = 2'd2
    } tc_class_e;

    localparam int FMT_LSB       = 5;
    localparam int FMT_MSB       = 7;
    localparam int FMT_DATA_BIT  = 1;
    localparam int LEN_HI_LSB    = 16;
    localparam int LEN_HI_MSB    = 17;
    localparam int LEN_LO_LSB    = 24;
    localparam int LEN_LO_MSB    = 31;
    localparam int LEN_W         = 10;
    localparam int DATA_CRED_DIV = 4;
    localparam int MAX_LEN_DW    = 1024;
    localparam int NEED_CRED_W   = 9;

    function automatic logic [2:0] tl_hdr_fmt(input logic [31:0] dw0);
        return dw0[FMT_MSB:FMT_LSB];
    endfunction

    function automatic logic [LEN_W-1:0] tl_hdr_len(input logic [31:0] dw0);
        return {dw0[LEN_HI_MSB:LEN_HI_LSB], dw0[LEN_LO_MSB:LEN_LO_LSB]};
    endfunction

    // A zero Length field encodes the maximum payload of 1024 DW.
    function automatic logic [NEED_CRED_W-1:0] tl_data_credits(input logic [2:0]       fmt,
                                                               input logic [LEN_W-1:0] len);
        logic [LEN_W:0] len_dw;
        len_dw = (len == '0) ? (LEN_W+1)'(MAX_LEN_DW) : {1'b0, len};
        if (fmt[FMT_DATA_BIT])
            return NEED_CRED_W'((len_dw + (LEN_W+1)'(DATA_CRED_DIV - 1)) / (LEN_W+1)'(DATA_CRED_DIV));
        return '0;
    endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry valid/ready buffer for tl_stream_t beats with a registered output
// stage; sustains one beat per cycle and holds the output stable under stall.
module tl_skid_buf
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  tl_stream_t in_pkt,
    input  logic       in_valid,
    output logic       in_space,
    output tl_stream_t out_pkt,
    output logic       out_valid,
    input  logic       out_ready
);

    tl_stream_t spare_pkt;
    logic       spare_vld;
    logic       pop;
    logic       push;

    assign pop      = out_valid & out_ready;
    assign in_space = ~spare_vld | pop;
    assign push     = in_valid & in_space;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            spare_vld <= 1'b0;
            out_pkt   <= '0;
        end else if (pop) begin
            if (spare_vld) begin
                out_pkt   <= spare_pkt;
                spare_vld <= push;
            end else begin
                out_valid <= push;
                if (push)
                    out_pkt <= in_pkt;
            end
        end else if (push) begin
            if (!out_valid) begin
                out_pkt   <= in_pkt;
                out_valid <= 1'b1;
            end else begin
                spare_vld <= 1'b1;
            end
        end
    end

    // Spare entry catches the incoming beat whenever the output stage stays occupied.
    always_ff @(posedge clk) begin
        if (push && (pop ? spare_vld : out_valid))
            spare_pkt <= in_pkt;
    end

endmodule

// File: rtl/tl_tx_arbiter.sv
// Round-robin packet arbiter over the P/NP/CPL queue heads with SOP credit
// checks, whole-packet locking and a skid-buffered link to the DLL.
module tl_tx_arbiter
    import tl_pkg::*;
#(
    parameter int HDR_CRED_W  = 8,
    parameter int DATA_CRED_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  tl_stream_t             p_pkt_i,
    input  logic                   p_valid_i,
    output logic                   p_ready_o,
    input  tl_stream_t             np_pkt_i,
    input  logic                   np_valid_i,
    output logic                   np_ready_o,
    input  tl_stream_t             cpl_pkt_i,
    input  logic                   cpl_valid_i,
    output logic                   cpl_ready_o,
    input  logic [HDR_CRED_W-1:0]  p_hdr_cred_i,
    input  logic [HDR_CRED_W-1:0]  np_hdr_cred_i,
    input  logic [HDR_CRED_W-1:0]  cpl_hdr_cred_i,
    input  logic [DATA_CRED_W-1:0] p_data_cred_i,
    input  logic [DATA_CRED_W-1:0] np_data_cred_i,
    input  logic [DATA_CRED_W-1:0] cpl_data_cred_i,
    output logic                   cons_valid_o,
    output logic [1:0]             cons_class_o,
    output logic [DATA_CRED_W-1:0] cons_data_o,
    output tl_stream_t             dll_pkt_o,
    output logic                   dll_valid_o,
    input  logic                   dll_ready_i,
    output logic                   proto_err_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e    state, state_nxt;
    tc_class_e rr_ptr, rr_nxt;
    tc_class_e lock_cls, lock_nxt;
    tc_class_e gsel;

    tl_stream_t             pkt_a  [3];
    logic [HDR_CRED_W-1:0]  hdr_a  [3];
    logic [DATA_CRED_W-1:0] dcr_a  [3];
    logic [NEED_CRED_W-1:0] need_a [3];
    logic [2:0]             vld_a;
    logic [2:0]             elig;
    logic [2:0]             err_a;
    logic [2:0]             rdy;

    tl_stream_t push_pkt;
    logic       push;
    logic       skid_space;

    assign pkt_a[0] = p_pkt_i;
    assign pkt_a[1] = np_pkt_i;
    assign pkt_a[2] = cpl_pkt_i;
    assign hdr_a[0] = p_hdr_cred_i;
    assign hdr_a[1] = np_hdr_cred_i;
    assign hdr_a[2] = cpl_hdr_cred_i;
    assign dcr_a[0] = p_data_cred_i;
    assign dcr_a[1] = np_data_cred_i;
    assign dcr_a[2] = cpl_data_cred_i;
    assign vld_a    = {cpl_valid_i, np_valid_i, p_valid_i};

    for (genvar g = 0; g < 3; g++) begin : g_cls
        assign need_a[g] = tl_data_credits(tl_hdr_fmt(pkt_a[g].data), tl_hdr_len(pkt_a[g].data));
        assign elig[g]   = vld_a[g] & pkt_a[g].sop & (hdr_a[g] != '0) &
                           (dcr_a[g] >= DATA_CRED_W'(need_a[g]));
        assign err_a[g]  = vld_a[g] & ~pkt_a[g].sop;
    end

    function automatic logic [1:0] rr_first(input logic [1:0] ptr, input logic [2:0] el);
        logic [1:0] sel;
        logic       hit;
        logic [1:0] idx;
        sel = ptr;
        hit = 1'b0;
        idx = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!hit && el[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return sel;
    endfunction

    function automatic tc_class_e rr_after(input tc_class_e cls);
        case (cls)
            TC_P:    return TC_NP;
            TC_NP:   return TC_CPL;
            default: return TC_P;
        endcase
    endfunction

    assign gsel = tc_class_e'(rr_first(rr_ptr, elig));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= TC_P;
            lock_cls <= TC_P;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            lock_cls <= lock_nxt;
        end
    end

    // Stray non-SOP heads are flushed before any grant; a grant needs skid room.
    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr_ptr;
        lock_nxt     = lock_cls;
        rdy          = '0;
        push         = 1'b0;
        push_pkt     = pkt_a[lock_cls];
        cons_valid_o = 1'b0;
        cons_class_o = 2'd0;
        cons_data_o  = '0;
        proto_err_o  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (|err_a) begin
                        proto_err_o = 1'b1;
                        if (err_a[0])
                            rdy[0] = 1'b1;
                        else if (err_a[1])
                            rdy[1] = 1'b1;
                        else
                            rdy[2] = 1'b1;
                    end else if (skid_space && (|elig)) begin
                        rdy[gsel]    = 1'b1;
                        push         = 1'b1;
                        push_pkt     = pkt_a[gsel];
                        cons_valid_o = 1'b1;
                        cons_class_o = gsel;
                        cons_data_o  = DATA_CRED_W'(need_a[gsel]);
                        rr_nxt       = rr_after(gsel);
                        if (!pkt_a[gsel].eop) begin
                            state_nxt = ST_XFER;
                            lock_nxt  = gsel;
                        end
                    end
                end
                default: begin
                    rdy[lock_cls] = skid_space;
                    push          = vld_a[lock_cls] & skid_space;
                    if (push && pkt_a[lock_cls].eop)
                        state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign p_ready_o   = rdy[0];
    assign np_ready_o  = rdy[1];
    assign cpl_ready_o = rdy[2];

    tl_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_pkt    (push_pkt),
        .in_valid  (push),
        .in_space  (skid_space),
        .out_pkt   (dll_pkt_o),
        .out_valid (dll_valid_o),
        .out_ready (dll_ready_i)
    );

endmodule

// File: doc/tl_tx_arbiter.md
Name: tl_tx_arbiter

Overview:
- Downstream stage of the TX queue router.
- Pulls packets from the heads of the Posted, Non-Posted and Completion queues and arbitrates among them round-robin, with per-class flow-control credit checks at SOP.
- Forwards whole packets, never interleaved, to the data link layer through a registered 2-entry skid buffer.
- Reports credit consumption to the flow-control tracker.

Parameters:
- HDR_CRED_W, 8, width of header-credit available inputs.
- DATA_CRED_W, 12, width of data-credit available inputs and consumed outputs (1 credit = 4 DW).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- p_pkt_i  input  tl_stream_t  Posted queue head beat.
- p_valid_i  input  1  Posted head valid.
- p_ready_o  output  1  Posted head accept.
- np_pkt_i / np_valid_i / np_ready_o  as above, Non-Posted queue.
- cpl_pkt_i / cpl_valid_i / cpl_ready_o  as above, Completion queue.
- p_hdr_cred_i, np_hdr_cred_i, cpl_hdr_cred_i  input  HDR_CRED_W  header credits available per class.
- p_data_cred_i, np_data_cred_i, cpl_data_cred_i  input  DATA_CRED_W  data credits available per class.
- cons_valid_o  output  1  one-cycle pulse when a packet header is granted.
- cons_class_o  output  2  class of consumed credits (0=P, 1=NP, 2=CPL).
- cons_data_o  output  DATA_CRED_W  data credits consumed (0 if no payload).
- dll_pkt_o  output  tl_stream_t  beat to data link layer.
- dll_valid_o  output  1  beat valid.
- dll_ready_i  input  1  DLL accept.
- proto_err_o  output  1  one-cycle pulse when a non-SOP beat is dropped in IDLE.

Behaviour:
- Header decode at SOP:
  - fmt = data[7:5]; Length = {data[17:16], data[31:24]}; Length 0 means 1024 DW.
  - Data credits needed: ceil(Length/4) if fmt[1]=1, else 0. Range 1..256.
- Class eligibility: valid & sop & hdr_cred>=1 & data_cred>=needed.
- States: IDLE, XFER.
  - IDLE:
    - If skid has space and at least one class is eligible, grant the first eligible class starting at rr_ptr (P to NP to CPL to P).
    - Grant: assert that queue's ready, write the beat into the skid, pulse cons_* in the same cycle, set rr_ptr = granted+1 mod 3.
    - If the granted beat has eop: stay IDLE. Otherwise: lock the class, go to XFER.
  - XFER:
    - Only the locked queue's ready may be high, and only when the skid has space.
    - Other classes are ignored.
    - On an accepted eop beat, go to IDLE.
    - Beats are passed through unmodified.
  - IDLE error case: if a queue head is valid with sop=0, it is dropped (ready=1 for one cycle, highest-priority such queue only) and proto_err_o pulses. This takes precedence over a grant in that cycle.
- Credit hold: a class whose head is SOP but is credit-blocked is skipped; the next eligible class is granted. rr_ptr advances only on grant. No grants occur when no class is eligible.
- Credit inputs are sampled combinationally in the grant cycle. Credit decrement is the tracker's job, triggered by cons_valid_o.
- At most one of p/np/cpl ready is high in any cycle.
- Skid buffer:
  - 2 entries, registered output, full throughput.
  - Latency is 1 cycle from queue accept to dll_valid_o.
  - dll_pkt_o is held stable while dll_valid_o=1 and dll_ready_i=0.
  - Space = fewer than 2 entries, or 2 entries and a pop is happening this cycle.
- Reset (including mid-packet):
  - State goes to IDLE, rr_ptr=P, skid emptied.
  - All ready/valid/cons_valid_o/proto_err_o = 0; cons_class_o=0; cons_data_o=0; dll_pkt_o='0.
  - Partially forwarded packets are abandoned; the DLL is responsible for discarding them.
- Simultaneous events: a grant and a skid pop in the same cycle are allowed. A grant in the same cycle as the previous packet's eop accept is not allowed: the next grant is evaluated the cycle after returning to IDLE (one bubble per multi-beat packet end).

Decomposition:
- tl_pkg additions:
  - tc_class_e enum (TC_P=0, TC_NP=1, TC_CPL=2).
  - Header field constants for fmt, the Length bit positions, DATA_CRED_DIV=4, and MAX_LEN_DW=1024.
  - Function tl_data_credits(fmt, len).
- Sub-module: tl_skid_buf (2-entry tl_stream_t valid/ready buffer), reusable elsewhere in TX.

Test Plan:
- Single-beat MRd on NP (fmt=000, len=1), np_hdr_cred=4 -> np_ready_o=1 for one cycle; cons_valid_o=1, cons_class_o=1, cons_data_o=0; dll_valid_o one cycle later with identical beat.
- All three queues hold 1-beat packets continuously, credits plentiful -> grant order P,NP,CPL,P,NP,CPL; dll_valid_o stays high every cycle with dll_ready_i=1.
- P MWr len=0 (1024 DW) and p_data_cred=255, NP MRd ready -> P skipped, NP granted; raise p_data_cred to 256 -> P granted, cons_data_o=256.
- 4-beat CPL packet, then P SOP presented mid-packet -> p_ready_o stays 0 until CPL eop is accepted; P granted after one bubble cycle.
- dll_ready_i=0 for 5 cycles during a 6-beat P packet -> skid fills to 2 and p_ready_o drops; no beat is lost or duplicated; dll_pkt_o is stable while stalled.
- Non-SOP beat at NP head in IDLE -> beat dropped, proto_err_o pulses once. Separately, assert rst for 1 cycle mid-packet -> all outputs 0 next cycle; the next P SOP is granted first.
